// File: rtl/frame_buffer_scanner.sv
// 640x480@60 VGA scan-out of a 128x64 double-buffered framebuffer, pixels scaled SCALE x SCALE.
// Build with TEST_PATTERN_EN defined to add a test_pat input that replaces in-window pixels with colour bars.
module frame_buffer_scanner #(
  parameter int          COL_W      = 7,
  parameter int          ROW_W      = 6,
  parameter int          PIX_W      = 12,
  parameter int          CLK_DIV    = 4,
  parameter int          SCALE      = 4,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TEST_PATTERN_EN
  input  logic             test_pat,
`endif
  output logic [COL_W-1:0] rd_col,
  output logic [ROW_W-1:0] rd_row,
  input  logic [PIX_W-1:0] rd_data,
  output logic             buf_sel,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             frame_start,
  output logic             hs,
  output logic             vs,
  output logic [11:0]      rgb
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SH     = $clog2(SCALE);
  localparam int IMG_W  = (1 << COL_W) * SCALE;
  localparam int IMG_H  = (1 << ROW_W) * SCALE;
  localparam int X0     = (640 - IMG_W) / 2;
  localparam int Y0     = (480 - IMG_H) / 2;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             buf_sel_q, buf_sel_d;
  logic             swap_ack_q, swap_ack_d;
  logic             frame_start_q, frame_start_d;

  logic             tick, next_in, cur_in, cur_act, vblank_edge;
  logic [11:0]      pix;

  always_comb begin
    tick    = (div_q == DIV_W'(CLK_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);

    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == 10'd799) begin
        h_d = 10'd0;
        v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Address follows the position being entered so rd_data is ready by the next tick.
    next_in = (h_d >= 10'(X0)) && (h_d < 10'(X0 + IMG_W)) &&
              (v_d >= 10'(Y0)) && (v_d < 10'(Y0 + IMG_H));
    cur_in  = (h_q >= 10'(X0)) && (h_q < 10'(X0 + IMG_W)) &&
              (v_q >= 10'(Y0)) && (v_q < 10'(Y0 + IMG_H));
    cur_act = (h_q < 10'd640) && (v_q < 10'd480);

    rd_col_d = rd_col_q;
    rd_row_d = rd_row_q;
    if (tick && next_in) begin
      rd_col_d = COL_W'((h_d - 10'(X0)) >> SH);
      rd_row_d = ROW_W'((v_d - 10'(Y0)) >> SH);
    end

    pix = 12'h000;
    if (cur_in) begin
      pix = 12'(rd_data);
`ifdef TEST_PATTERN_EN
      if (test_pat) begin
        pix = {{4{rd_col_q[COL_W-1]}}, {4{rd_col_q[COL_W-2]}}, {4{rd_col_q[COL_W-3]}}};
      end
`endif
    end else if (cur_act) begin
      pix = BORDER_RGB;
    end

    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      rgb_d = pix;
      hs_d  = !((h_q >= 10'd656) && (h_q < 10'd752));
      vs_d  = !((v_q >= 10'd490) && (v_q < 10'd492));
    end

    vblank_edge   = tick && (h_q == 10'd799) && (v_q == 10'd479);
    frame_start_d = vblank_edge;
    swap_ack_d    = vblank_edge && swap_req;
    buf_sel_d     = buf_sel_q ^ (vblank_edge && swap_req);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rd_col_q      <= '0;
      rd_row_q      <= '0;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      buf_sel_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rd_col_q      <= rd_col_d;
      rd_row_q      <= rd_row_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      buf_sel_q     <= buf_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rd_col      = rd_col_q;
  assign rd_row      = rd_row_q;
  assign rgb         = rgb_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign buf_sel     = buf_sel_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_buffer_scanner.sv
// Scoreboard bench for frame_buffer_scanner: expected values keyed by VGA tick index, popped by a monitor.
module tb_frame_buffer_scanner;

  localparam int          CLK_DIV = 2;
  localparam logic [11:0] BORDER  = 12'h0F0;
  localparam int          END_K   = 804002 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  rd_col;
  logic [5:0]  rd_row;
  logic [11:0] rd_data = 12'h000;
  logic        buf_sel, swap_req, swap_ack, frame_start, hs, vs;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  frame_buffer_scanner #(
    .COL_W(7), .ROW_W(6), .PIX_W(12), .CLK_DIV(CLK_DIV), .SCALE(4), .BORDER_RGB(BORDER)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef TEST_PATTERN_EN
    .test_pat(1'b0),
`endif
    .rd_col(rd_col),
    .rd_row(rd_row),
    .rd_data(rd_data),
    .buf_sel(buf_sel),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .frame_start(frame_start),
    .hs(hs),
    .vs(vs),
    .rgb(rgb)
  );

  // Framebuffer model: 1-clk read latency, data encodes the address.
  always @(posedge clk) rd_data <= {rd_row[5:2], rd_col[6:3], 4'h5};

  typedef struct {
    int    tick;
    string name;
    int    sig;
    int    exp;
  } chk_t;

  chk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   ack_cnt = 0;
  int   fs_clks = 0;

  localparam int S_HS = 0, S_VS = 1, S_RGB = 2, S_COL = 3, S_ROW = 4,
                 S_BUF = 5, S_FS = 6, S_ACK = 7;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endfunction

  function automatic int get_sig(int id);
    case (id)
      S_HS:    return int'(hs);
      S_VS:    return int'(vs);
      S_RGB:   return int'(rgb);
      S_COL:   return int'(rd_col);
      S_ROW:   return int'(rd_row);
      S_BUF:   return int'(buf_sel);
      S_FS:    return int'(frame_start);
      default: return int'(swap_ack);
    endcase
  endfunction

  task automatic push(input int t, input string nm, input int s, input int e);
    chk_t c;
    c.tick = t; c.name = nm; c.sig = s; c.exp = e;
    exp_q.push_back(c);
  endtask

  always @(posedge clk) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // Tick n lands on clk edge n*CLK_DIV after release; sample on the following falling edge.
  always @(negedge clk) begin
    chk_t e;
    int   n;
    if (rst) begin
      if (swap_ack)    ack_cnt++;
      if (frame_start) fs_clks++;
      if (k > 0 && (k % CLK_DIV) == 0) begin
        n = k / CLK_DIV;
        while (exp_q.size() > 0 && exp_q[0].tick <= n) begin
          e = exp_q.pop_front();
          if (e.tick < n) check({e.name, "_missed"}, n, e.tick);
          else            check(e.name, get_sig(e.sig), e.exp);
        end
      end
    end
  end

  // Host swap request: raise at line 200, drop once acknowledged.
  initial begin
    int guard;
    swap_req = 1'b0;
    while (k < 160000 * CLK_DIV) @(negedge clk);
    swap_req = 1'b1;
    guard = 0;
    while (!swap_ack && guard < 600000) begin
      @(negedge clk);
      guard++;
    end
    check("swap_ack_seen", int'(swap_ack), 1);
    swap_req = 1'b0;
  end

  initial begin
    push(656,    "hs_before_sync",  S_HS,  1);
    push(657,    "hs_first_low",    S_HS,  0);
    push(752,    "hs_last_low",     S_HS,  0);
    push(753,    "hs_release",      S_HS,  1);
    push(1456,   "hs_line1_pre",    S_HS,  1);
    push(1457,   "hs_line1_low",    S_HS,  0);
    push(8011,   "border_h10_v10",  S_RGB, 12'h0F0);
    push(8640,   "border_h639",     S_RGB, 12'h0F0);
    push(8641,   "blank_h640",      S_RGB, 0);
    push(8701,   "blank_h700",      S_RGB, 0);
    push(88901,  "border_v111",     S_RGB, 12'h0F0);
    push(89664,  "col_first",       S_COL, 0);
    push(89664,  "row_first",       S_ROW, 0);
    push(89665,  "rgb_first",       S_RGB, 12'h005);
    push(89668,  "col_h68",         S_COL, 1);
    push(89696,  "col_h96",         S_COL, 8);
    push(89697,  "rgb_h96",         S_RGB, 12'h015);
    push(90200,  "col_hold_right",  S_COL, 127);
    push(90463,  "col_hold_left",   S_COL, 127);
    push(90463,  "row_hold_left",   S_ROW, 0);
    push(160000, "buf_sel_pre",     S_BUF, 0);
    push(160064, "border_h63",      S_RGB, 12'h0F0);
    push(160300, "col_mid",         S_COL, 59);
    push(160300, "row_mid",         S_ROW, 22);
    push(160301, "rgb_mid",         S_RGB, 12'h575);
    push(293701, "rgb_last_row",    S_RGB, 12'hF15);
    push(294175, "col_last",        S_COL, 127);
    push(294175, "row_last",        S_ROW, 63);
    push(294176, "rgb_last",        S_RGB, 12'hFF5);
    push(294177, "border_h576",     S_RGB, 12'h0F0);
    push(294501, "border_v368",     S_RGB, 12'h0F0);
    push(383999, "fs_before",       S_FS,  0);
    push(383999, "buf_sel_before",  S_BUF, 0);
    push(384000, "fs_vblank1",      S_FS,  1);
    push(384000, "ack_vblank1",     S_ACK, 1);
    push(384000, "buf_sel_swapped", S_BUF, 1);
    push(384001, "fs_single",       S_FS,  0);
    push(392000, "vs_pre",          S_VS,  1);
    push(392001, "vs_first_low",    S_VS,  0);
    push(393600, "vs_last_low",     S_VS,  0);
    push(393601, "vs_release",      S_VS,  1);
    push(400011, "blank_v500",      S_RGB, 0);
    push(400657, "hs_in_vblank",    S_HS,  0);
    push(804000, "fs_vblank2",      S_FS,  1);
    push(804000, "ack_vblank2",     S_ACK, 0);
    push(804000, "buf_sel_kept",    S_BUF, 1);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hs",          int'(hs), 1);
    check("rst_vs",          int'(vs), 1);
    check("rst_rgb",         int'(rgb), 0);
    check("rst_buf_sel",     int'(buf_sel), 0);
    check("rst_rd_col",      int'(rd_col), 0);
    check("rst_rd_row",      int'(rd_row), 0);
    check("rst_swap_ack",    int'(swap_ack), 0);
    check("rst_frame_start", int'(frame_start), 0);
    rst = 1'b1;

    while (k < END_K) @(negedge clk);

    check("queue_drained",   exp_q.size(), 0);
    check("swap_ack_count",  ack_cnt, 1);
    check("frame_start_clks", fs_clks, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
